// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative multiply/divide sequencer that owns the HI/LO registers.
// Runs a 1-bit-per-cycle shift-add multiplier or restoring divider for
// MULT/MULTU/DIV/DIVU, and services MTHI/MTLO writes while idle.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous reset, active-low
//   start   in   HI/LO-writing op presented this cycle
//   op      in   0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, 6/7 no-op
//   rs_val  in   operand A / dividend / MTHI-MTLO data
//   rt_val  in   operand B / divisor
//   rd_req  in   MFHI/MFLO in execute this cycle
//   busy    out  iteration in progress (registered)
//   stall   out  freeze pipeline front end (combinational)
//   done    out  one-cycle pulse, new HI/LO visible this cycle
//   hi      out  HI register
//   lo      out  LO register
module muldiv_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             rd_req,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned AW = 2 * WIDTH;

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // acc holds {partial_hi, multiplier} for multiply, {remainder, quotient} for divide
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rs_q, rs_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Operand conditioning at capture
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        signed_op = ~op[2] & ~op[0];
        a_neg     = signed_op & rs_val[WIDTH-1];
        b_neg     = signed_op & rt_val[WIDTH-1];
        a_mag     = a_neg ? -rs_val : rs_val;
        b_mag     = b_neg ? -rt_val : rt_val;
    end

    // One iteration of each algorithm, plus the sign fix-up applied in FIX
    logic [WIDTH:0]   mul_upper;
    logic [AW-1:0]    mul_next;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [AW-1:0]    div_next;
    logic [AW-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        mul_upper = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next  = {mul_upper, acc_q[WIDTH-1:1]};

        div_sh    = acc_q[AW-1:WIDTH-1];
        div_ge    = div_sh >= {1'b0, b_q};
        div_diff  = WIDTH'(div_sh - {1'b0, b_q});
        div_next  = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

        prod_fix  = neg_q ? -acc_q : acc_q;
        quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = neg_rem_q ? -acc_q[AW-1:WIDTH] : acc_q[AW-1:WIDTH];
    end

    // Next-state and register-update logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_d       = b_q;
        rs_d      = rs_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (!op[2]) begin
                        state_d   = S_RUN;
                        cnt_d     = CW'(WIDTH - 1);
                        acc_d     = {{WIDTH{1'b0}}, a_mag};
                        b_d       = b_mag;
                        rs_d      = rs_val;
                        is_div_d  = op[1];
                        neg_d     = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                    end else if (op == OP_MTHI) begin
                        hi_d = rs_val;
                    end else if (op == OP_MTLO) begin
                        lo_d = rs_val;
                    end
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod_fix[AW-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (b_q == '0) begin
                    // divide by zero: all-ones quotient, raw dividend as remainder
                    hi_d = rs_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            rs_q      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            rs_q      <= rs_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    // Holds any HI/LO access that arrives while an iteration is running
    assign stall = busy_q & (start | rd_req);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl (WIDTH=32).
module tb_muldiv_ctrl;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         rd_req;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .rd_req (rd_req),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result of an op, from plain integer arithmetic
    function automatic logic [63:0] model_calc(input logic [2:0] mop, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        case (mop)
            3'd0: begin sp = sa * sb; r = sp; end
            3'd1: begin up = ua * ub; r = up; end
            3'd2: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {sr[31:0], sq[31:0]};
                end
            end
            3'd3: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else r = {32'(ua % ub), 32'(ua / ub)};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Cycle-level behavioural model: an op occupies W+1 busy cycles, result lands after the last
    int          m_left = 0;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_done;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left == 0) begin
                if (start && op < 3'd4) begin
                    m_left <= W + 1;
                    {p_hi, p_lo} <= model_calc(op, rs_val, rt_val);
                end else if (start && op == 3'd4) begin
                    m_hi <= rs_val;
                end else if (start && op == 3'd5) begin
                    m_lo <= rs_val;
                end
            end else begin
                if (m_left == 1) begin
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                    m_done <= 1'b1;
                end
                m_left <= m_left - 1;
            end
        end
    end

    // Compare every cycle against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy",  32'(busy),  32'(m_left != 0));
            check("cyc_done",  32'(done),  32'(m_done));
            check("cyc_stall", 32'(stall), 32'((m_left != 0) && (start || rd_req)));
            check("cyc_hi",    hi,         m_hi);
            check("cyc_lo",    lo,         m_lo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue an op in the current cycle, scramble inputs, wait for done, check literals
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int n;
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        tick();
        start  = 1'b0;
        op     = 3'd4;
        rs_val = $urandom;
        rt_val = $urandom;
        n = 1;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check({name, "_latency"}, 32'(n), 32'(W + 2));
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_lo"}, lo, exp_lo);
        check({name, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int pulses;
        rst = 1'b0; start = 1'b0; rd_req = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0;
        repeat (3) tick();
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b1;
        chk_en = 1'b1;
        tick();

        run_op("multu_3x5", 3'd1, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F);
        run_op("mult_neg",  3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_neg7",  3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7_m2",  3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu_by0",  3'd3, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF);
        run_op("div_by0",   3'd2, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        run_op("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // MTLO / MTHI in idle
        start = 1'b1; op = 3'd5; rs_val = 32'hDEAD_BEEF;
        tick();
        start = 1'b0;
        check("mtlo_lo", lo, 32'hDEAD_BEEF);
        check("mtlo_busy", 32'(busy), 32'd0);
        check("mtlo_done", 32'(done), 32'd0);
        start = 1'b1; op = 3'd4; rs_val = 32'hCAFE_F00D;
        tick();
        start = 1'b0;
        check("mthi_hi", hi, 32'hCAFE_F00D);
        check("mthi_lo_kept", lo, 32'hDEAD_BEEF);

        // No-op codes are ignored
        start = 1'b1; op = 3'd6; rs_val = 32'h1111_1111;
        #1 check("nop_stall", 32'(stall), 32'd0);
        tick();
        op = 3'd7;
        tick();
        start = 1'b0;
        check("nop_busy", 32'(busy), 32'd0);
        check("nop_hi", hi, 32'hCAFE_F00D);

        // Second start + MFHI while busy: stalled and held until accepted in the done cycle
        start = 1'b1; op = 3'd1; rs_val = 32'd2; rt_val = 32'd2;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1; op = 3'd1; rs_val = 32'd3; rt_val = 32'd3; rd_req = 1'b1;
        #1 check("stall_c5", 32'(stall), 32'd1);
        n = 5;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check("stall_done_cycle", 32'(n), 32'(W + 2));
        check("stall_first_hi", hi, 32'h0);
        check("stall_first_lo", lo, 32'h4);
        #1 check("stall_clear_at_done", 32'(stall), 32'd0);
        tick();
        start = 1'b0; rd_req = 1'b0;
        n = 1;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check("second_latency", 32'(n), 32'(W + 2));
        check("second_lo", lo, 32'h9);

        // MTHI arriving in cycle 10 of a MULT is dropped
        start = 1'b1; op = 3'd0; rs_val = 32'hFFFF_FFFE; rt_val = 32'd3;
        tick();
        start = 1'b0;
        repeat (9) tick();
        start = 1'b1; op = 3'd4; rs_val = 32'h1234_5678;
        tick();
        start = 1'b0;
        n = 11;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check("mthi_busy_hi", hi, 32'hFFFF_FFFF);
        check("mthi_busy_lo", lo, 32'hFFFF_FFFA);

        // Reset in cycle 10 of DIVU aborts it
        start = 1'b1; op = 3'd3; rs_val = 32'd100; rt_val = 32'd7;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b0;
        tick();
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        check("abort_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E);

        // Reset wins over a simultaneous start
        rst = 1'b0; start = 1'b1; op = 3'd1; rs_val = 32'd3; rt_val = 32'd5;
        tick();
        rst = 1'b1; start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        check("rst_start_lo", lo, 32'h0);
        repeat (3) tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
